// File: rtl/crypto1_mul_pipe_sat.sv
// Pipelined signed multiplier with arithmetic right shift and wrap/saturate narrowing.
// Latency is NUM_STAGE ce=1 edges; ce=0 freezes every stage, reset clears every stage.
module crypto1_mul_pipe_sat #(
  parameter int unsigned ID         = 1,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned din0_WIDTH = 14,
  parameter int unsigned din1_WIDTH = 12,
  parameter int unsigned dout_WIDTH = 12,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  sat_en,
  output logic                  out_valid,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int unsigned PW = din0_WIDTH + din1_WIDTH;
  // Bits of the shifted product that must all agree for the value to fit in dout.
  localparam int unsigned HW = PW - dout_WIDTH + 1;

  if (NUM_STAGE < 1 || NUM_STAGE > 6) begin : g_bad_stage
    $error("crypto1_mul_pipe_sat: NUM_STAGE must be 1..6");
  end
  if (dout_WIDTH < 2 || dout_WIDTH > PW) begin : g_bad_dout
    $error("crypto1_mul_pipe_sat: dout_WIDTH must be 2..din0_WIDTH+din1_WIDTH");
  end
  if (SHIFT > PW - 1) begin : g_bad_shift
    $error("crypto1_mul_pipe_sat: SHIFT must be 0..din0_WIDTH+din1_WIDTH-1");
  end

  logic unused_id;
  assign unused_id = (ID == 0);

  // Product, saturation mode and valid as seen by the narrowing logic.
  logic signed [PW-1:0] p_last;
  logic                 sat_last;
  logic                 vld_last;

  if (NUM_STAGE == 1) begin : g_one
    // Single register layer: multiply, shift and narrow all feed the output register.
    assign p_last   = $signed(din0) * $signed(din1);
    assign sat_last = sat_en;
    assign vld_last = in_valid;
  end else begin : g_multi
    logic signed [din0_WIDTH-1:0] a_q;
    logic signed [din1_WIDTH-1:0] b_q;
    logic                         sat1_q;
    logic                         vld1_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        a_q    <= '0;
        b_q    <= '0;
        sat1_q <= 1'b0;
        vld1_q <= 1'b0;
      end else if (ce) begin
        a_q    <= din0;
        b_q    <= din1;
        sat1_q <= sat_en;
        vld1_q <= in_valid;
      end
    end

    if (NUM_STAGE == 2) begin : g_direct
      assign p_last   = a_q * b_q;
      assign sat_last = sat1_q;
      assign vld_last = vld1_q;
    end else begin : g_prod
      localparam int unsigned PD = NUM_STAGE - 2;

      logic signed [PW-1:0] p_q   [PD];
      logic                 sat_q [PD];
      logic                 vld_q [PD];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PD; i++) begin
            p_q[i]   <= '0;
            sat_q[i] <= 1'b0;
            vld_q[i] <= 1'b0;
          end
        end else if (ce) begin
          p_q[0]   <= a_q * b_q;
          sat_q[0] <= sat1_q;
          vld_q[0] <= vld1_q;
          for (int i = 1; i < PD; i++) begin
            p_q[i]   <= p_q[i-1];
            sat_q[i] <= sat_q[i-1];
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      assign p_last   = p_q[PD-1];
      assign sat_last = sat_q[PD-1];
      assign vld_last = vld_q[PD-1];
    end
  end

  logic signed [PW-1:0]   s_full;
  logic        [HW-1:0]   s_hi;
  logic                   fits;
  logic [dout_WIDTH-1:0]  dout_d;
  logic                   ovf_d;
  logic [dout_WIDTH-1:0]  sat_max;
  logic [dout_WIDTH-1:0]  sat_min;

  assign s_full  = p_last >>> SHIFT;
  assign s_hi    = s_full[PW-1:dout_WIDTH-1];
  assign fits    = (&s_hi) | ~(|s_hi);
  assign sat_max = {1'b0, {(dout_WIDTH - 1){1'b1}}};
  assign sat_min = {1'b1, {(dout_WIDTH - 1){1'b0}}};

  always_comb begin
    dout_d = s_full[dout_WIDTH-1:0];
    ovf_d  = 1'b0;
    if (!fits) begin
      ovf_d = 1'b1;
      if (sat_last) begin
        dout_d = s_full[PW-1] ? sat_min : sat_max;
      end
    end
  end

  logic                  vld_out_q;
  logic [dout_WIDTH-1:0] dout_q;
  logic                  ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_out_q <= 1'b0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
    end else if (ce) begin
      vld_out_q <= vld_last;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = vld_out_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_crypto1_mul_pipe_sat.sv
// Self-checking bench: four instances (default, SHIFT=4, NUM_STAGE=1, NUM_STAGE=6) share stimulus.
// Directed table, ce-stall and reset sequences, then a random stream against a behavioural model.
module tb_crypto1_mul_pipe_sat;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic [13:0] din0;
  logic [11:0] din1;
  logic        sat_en;

  logic        ov [4];
  logic [11:0] dq [4];
  logic        of [4];

  int total = 0;
  int bad   = 0;

  int nst [4] = '{3, 3, 1, 6};
  int shf [4] = '{0, 4, 0, 0};

  crypto1_mul_pipe_sat #(.NUM_STAGE(3)) u_def (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .sat_en(sat_en), .out_valid(ov[0]), .dout(dq[0]), .ovf(of[0])
  );
  crypto1_mul_pipe_sat #(.NUM_STAGE(3), .SHIFT(4)) u_sh (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .sat_en(sat_en), .out_valid(ov[1]), .dout(dq[1]), .ovf(of[1])
  );
  crypto1_mul_pipe_sat #(.NUM_STAGE(1)) u_n1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .sat_en(sat_en), .out_valid(ov[2]), .dout(dq[2]), .ovf(of[2])
  );
  crypto1_mul_pipe_sat #(.NUM_STAGE(6)) u_n6 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .sat_en(sat_en), .out_valid(ov[3]), .dout(dq[3]), .ovf(of[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int a;
    int b;
    bit s;
    int ed;
    bit eo;
  } vec_t;

  typedef struct {
    int d;
    bit o;
    int iss;
  } exp_t;

  vec_t tbl [20];
  exp_t q [4][$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic run_op(input int sel, input int a, input int b, input bit s,
                        input int ed, input bit eo);
    int lat;
    bit seen;
    din0     = 14'(a);
    din1     = 12'(b);
    sat_en   = s;
    in_valid = 1'b1;
    seen     = 1'b0;
    lat      = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      tick();
      in_valid = 1'b0;
      if (ov[sel]) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk($sformatf("latency a=%0d b=%0d", a, b), lat, 3);
    chk($sformatf("dout a=%0d b=%0d s=%0d", a, b, s), $signed(dq[sel]), ed);
    chk($sformatf("ovf a=%0d b=%0d s=%0d", a, b, s), of[sel], eo);
  endtask

  // Reference narrowing using plain integer arithmetic on a 64-bit product.
  function automatic void model(input int a, input int b, input bit s, input int sh,
                                output int d, output bit o);
    longint p;
    longint sv;
    logic [63:0] t;
    p  = longint'(a) * longint'(b);
    sv = p >>> sh;
    if (sv >= -2048 && sv <= 2047) begin
      d = int'(sv);
      o = 1'b0;
    end else begin
      o = 1'b1;
      if (s) begin
        d = (sv < 0) ? -2048 : 2047;
      end else begin
        t = sv;
        d = {{20{t[11]}}, t[11:0]};
      end
    end
  endfunction

  initial begin
    int ca [6];
    int cb [6];
    int edges;
    int a;
    int b;
    bit s;
    int d;
    bit o;
    exp_t e;

    tbl[0]  = '{0,     5,    -7, 1'b0,   -35, 1'b0};
    tbl[1]  = '{0,  8191,  2047, 1'b1,  2047, 1'b1};
    tbl[2]  = '{0,  8191,  2047, 1'b0, -2047, 1'b1};
    tbl[3]  = '{0, -8192,  2047, 1'b1, -2048, 1'b1};
    tbl[4]  = '{0, -8192, -2048, 1'b1,  2047, 1'b1};
    tbl[5]  = '{0, -8192, -2048, 1'b0,     0, 1'b1};
    tbl[6]  = '{0,     0, -1234, 1'b1,     0, 1'b0};
    tbl[7]  = '{0,    -1,    -1, 1'b0,     1, 1'b0};
    tbl[8]  = '{0,    45,    45, 1'b0,  2025, 1'b0};
    tbl[9]  = '{0,    46,    45, 1'b0, -2026, 1'b1};
    tbl[10] = '{0,   -64,    32, 1'b1, -2048, 1'b0};
    tbl[11] = '{0,    64,    32, 1'b1,  2047, 1'b1};
    tbl[12] = '{1,  -100,     3, 1'b0,   -19, 1'b0};
    tbl[13] = '{1,   100,     3, 1'b0,    18, 1'b0};
    tbl[14] = '{1,  8191,  2047, 1'b1,  2047, 1'b1};
    tbl[15] = '{1,    -1,     1, 1'b0,    -1, 1'b0};
    tbl[16] = '{1, -8192, -2048, 1'b0,     0, 1'b1};
    tbl[17] = '{1, -8192,  2047, 1'b1, -2048, 1'b1};
    tbl[18] = '{1,   -33,     1, 1'b0,    -3, 1'b0};
    tbl[19] = '{1,    15,     1, 1'b0,     0, 1'b0};

    ca = '{-8192, 0, -1, 8191, -8192, 5};
    cb = '{-2048, -77, -1, 0, -2048, 0};

    reset    = 1'b1;
    ce       = 1'b1;
    in_valid = 1'b0;
    din0     = '0;
    din1     = '0;
    sat_en   = 1'b0;

    // Reset state
    tick();
    tick();
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("reset out_valid inst%0d", j), ov[j], 0);
      chk($sformatf("reset dout inst%0d", j), dq[j], 0);
      chk($sformatf("reset ovf inst%0d", j), of[j], 0);
    end
    reset = 1'b0;
    tick();
    chk("post-reset out_valid", ov[0], 0);
    chk("post-reset dout", dq[0], 0);

    // Directed table
    for (int i = 0; i < 20; i++) begin
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].ed, tbl[i].eo);
    end
    for (int i = 0; i < 8; i++) tick();

    // ce stall mid-flight: 1*2, 3*4, -5*6 back to back
    sat_en = 1'b0;
    in_valid = 1'b1; din0 = 14'(1);  din1 = 12'(2); tick();
    in_valid = 1'b1; din0 = 14'(3);  din1 = 12'(4); tick();
    in_valid = 1'b1; din0 = 14'(-5); din1 = 12'(6); tick();
    chk("stall first out_valid", ov[0], 1);
    chk("stall first dout", $signed(dq[0]), 2);
    ce = 1'b0;
    din0 = 14'(77);
    din1 = 12'(77);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall hold out_valid c%0d", i), ov[0], 1);
      chk($sformatf("stall hold dout c%0d", i), $signed(dq[0]), 2);
    end
    in_valid = 1'b0;
    ce = 1'b1;
    tick();
    chk("stall second out_valid", ov[0], 1);
    chk("stall second dout", $signed(dq[0]), 12);
    tick();
    chk("stall third out_valid", ov[0], 1);
    chk("stall third dout", $signed(dq[0]), -30);
    tick();
    chk("stall no duplicate", ov[0], 0);
    for (int i = 0; i < 8; i++) tick();

    // Reset mid-flight, with ce low to show reset dominates
    in_valid = 1'b1; din0 = 14'(9);  din1 = 12'(9); tick();
    in_valid = 1'b1; din0 = 14'(-9); din1 = 12'(9); tick();
    in_valid = 1'b0;
    reset = 1'b1;
    ce = 1'b0;
    tick();
    reset = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flushed out_valid c%0d", i), ov[0], 0);
    end
    run_op(0, 7, -3, 1'b0, -21, 1'b0);
    for (int i = 0; i < 8; i++) tick();

    // Random stream with random ce, checked on all instances
    edges = 0;
    for (int k = 0; k < 10012; k++) begin
      if (k < 6) begin
        ce = 1'b1;
        in_valid = 1'b1;
        a = ca[k];
        b = cb[k];
        s = k[0];
      end else if (k < 10000) begin
        ce = ($urandom_range(0, 7) != 0);
        in_valid = ($urandom_range(0, 3) != 0);
        a = int'($signed(14'($urandom)));
        b = int'($signed(12'($urandom)));
        s = 1'($urandom_range(0, 1));
      end else begin
        ce = 1'b1;
        in_valid = 1'b0;
      end
      din0 = 14'(a);
      din1 = 12'(b);
      sat_en = s;
      if (ce && in_valid) begin
        for (int j = 0; j < 4; j++) begin
          model(a, b, s, shf[j], d, o);
          e = '{d, o, edges + 1};
          q[j].push_back(e);
        end
      end
      tick();
      if (ce) begin
        edges++;
        for (int j = 0; j < 4; j++) begin
          if (ov[j]) begin
            if (q[j].size() == 0) begin
              chk($sformatf("sweep spurious out_valid inst%0d", j), 1, 0);
            end else begin
              e = q[j].pop_front();
              chk($sformatf("sweep latency inst%0d", j), edges - e.iss + 1, nst[j]);
              chk($sformatf("sweep dout inst%0d", j), $signed(dq[j]), e.d);
              chk($sformatf("sweep ovf inst%0d", j), of[j], e.o);
            end
          end
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("sweep lost results inst%0d", j), q[j].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
